execute_unit: RTL

EXECUTE_UNIT -- requirements
Module: execute_unit

---
 rtl/execute_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/execute_unit.sv
// Single-issue ALU execute stage with a registered writeback port.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier; otherwise opcode 111 is rejected via illegal.
module execute_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        issue_op,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              wb_enable,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              illegal
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL} state_e;

  // Returns {carry, result}; carry is the carry-out for ADD and the borrow for SUB.
  function automatic logic [DATA_W:0] alu_op(input logic [2:0] op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_SHL:  r = {1'b0, a << b[3:0]};
      OP_SHR:  r = {1'b0, a >> b[3:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_e              state_q, state_d;
  logic                wb_en_q, wb_en_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic                illegal_q, illegal_d;
  logic [DATA_W:0]     alu_res;
  logic                accept;

`ifdef EXEC_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_step;
`endif

  assign issue_ready = (state_q == IDLE);
  assign accept      = issue_valid && issue_ready;
  assign alu_res     = alu_op(issue_op, operand_a, operand_b);

  always_comb begin
    state_d   = state_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    illegal_d = 1'b0;
`ifdef EXEC_MUL_EN
    busy_d    = busy_q;
    rd_d      = rd_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    if (accept) begin
      if (issue_op == OP_MUL) begin
`ifdef EXEC_MUL_EN
        state_d  = MUL;
        busy_d   = 1'b1;
        rd_d     = issue_rd;
        acc_d    = '0;
        mcand_d  = {{DATA_W{1'b0}}, operand_a};
        mplier_d = operand_b;
        cnt_d    = '0;
`else
        illegal_d = 1'b1;
`endif
      end else begin
        wb_en_d   = 1'b1;
        wb_addr_d = issue_rd;
        wb_data_d = alu_res[DATA_W-1:0];
        zero_d    = (alu_res[DATA_W-1:0] == '0);
        carry_d   = alu_res[DATA_W];
      end
    end

`ifdef EXEC_MUL_EN
    // One partial product per cycle; the last iteration writes back directly from the adder.
    if (state_q == MUL) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        wb_en_d   = 1'b1;
        wb_addr_d = rd_q;
        wb_data_d = acc_step[DATA_W-1:0];
        zero_d    = (acc_step[DATA_W-1:0] == '0);
        carry_d   = |acc_step[2*DATA_W-1:DATA_W];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef EXEC_MUL_EN
      busy_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
`ifdef EXEC_MUL_EN
      busy_q    <= busy_d;
`endif
    end
  end

`ifdef EXEC_MUL_EN
  // Multiplier datapath needs no reset: it is fully loaded on every MUL acceptance.
  always_ff @(posedge clk) begin
    rd_q     <= rd_d;
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    cnt_q    <= cnt_d;
  end

  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  assign wb_enable  = wb_en_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign illegal    = illegal_q;

endmodule
